// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// One transaction in flight: IDLE -> ADDR (addr_ok) -> DATA (data_ok) -> RESP (rvalid pulse).
module sram_port_arbiter #(
  parameter int DATA_PRIO = 1,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_rvalid,
  input  logic          data_req,
  input  logic [3:0]    data_wen,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_rvalid,
  output logic          stallreq_for_if,
  output logic          stallreq_for_mem,
  output logic          mem_req,
  output logic [3:0]    mem_wstrb,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata,
  output logic          proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;            // 1 = data port owns the transaction
  logic          last_grant_q, last_grant_d;  // 1 = data was granted last
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] inst_rdata_q, inst_rdata_d;
  logic [DW-1:0] data_rdata_q, data_rdata_d;
  logic          proto_err_q, proto_err_d;
  logic          any_req;
  logic          grant_data;

  always_comb begin
    any_req = inst_req | data_req;
    if (DATA_PRIO != 0) begin
      grant_data = data_req;
    end else begin
      // Round-robin: on contention the port that did not win last time goes next.
      grant_data = data_req & (~inst_req | ~last_grant_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      proto_err_q  <= proto_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ADDR;
      ADDR:    if (mem_addr_ok) state_d = DATA;
      DATA:    if (mem_data_ok) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    if (state_q == IDLE && any_req) begin
      owner_d      = grant_data;
      last_grant_d = grant_data;
      addr_d       = grant_data ? data_addr : inst_addr;
      wstrb_d      = grant_data ? data_wen : 4'b0000;
      wdata_d      = grant_data ? data_wdata : '0;
    end
    // Stores only acknowledge; the owner's last load value is preserved.
    if (state_q == DATA && mem_data_ok && wstrb_q == 4'b0000) begin
      if (owner_q) data_rdata_d = mem_rdata;
      else         inst_rdata_d = mem_rdata;
    end
    proto_err_d = proto_err_q | (mem_data_ok & (state_q != DATA));
  end

  always_comb begin
    mem_req          = (state_q == ADDR);
    inst_rvalid      = (state_q == RESP) & ~owner_q;
    data_rvalid      = (state_q == RESP) & owner_q;
    mem_wstrb        = wstrb_q;
    mem_addr         = addr_q;
    mem_wdata        = wdata_q;
    inst_rdata       = inst_rdata_q;
    data_rdata       = data_rdata_q;
    proto_err        = proto_err_q;
    stallreq_for_if  = inst_req & ~inst_rvalid;
    stallreq_for_mem = data_req & ~data_rvalid;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: dut0 uses data priority, dut1 round-robin.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req, inst_rvalid, data_req, data_rvalid;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wen, mem_wstrb;
  logic        stall_if, stall_mem, mem_req, mem_addr_ok, mem_data_ok, proto_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        r_inst_req, r_inst_rvalid, r_data_req, r_data_rvalid;
  logic [31:0] r_inst_addr, r_inst_rdata, r_data_addr, r_data_wdata, r_data_rdata;
  logic [3:0]  r_data_wen, r_mem_wstrb;
  logic        r_stall_if, r_stall_mem, r_mem_req, r_addr_ok, r_data_ok, r_proto_err;
  logic [31:0] r_mem_addr, r_mem_wdata, r_rdata;

  sram_port_arbiter #(.DATA_PRIO(1), .AW(32), .DW(32)) dut0 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_rvalid(data_rvalid),
    .stallreq_for_if(stall_if), .stallreq_for_mem(stall_mem),
    .mem_req(mem_req), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .proto_err(proto_err)
  );

  sram_port_arbiter #(.DATA_PRIO(0), .AW(32), .DW(32)) dut1 (
    .clk(clk), .rst(rst),
    .inst_req(r_inst_req), .inst_addr(r_inst_addr), .inst_rdata(r_inst_rdata), .inst_rvalid(r_inst_rvalid),
    .data_req(r_data_req), .data_wen(r_data_wen), .data_addr(r_data_addr), .data_wdata(r_data_wdata),
    .data_rdata(r_data_rdata), .data_rvalid(r_data_rvalid),
    .stallreq_for_if(r_stall_if), .stallreq_for_mem(r_stall_mem),
    .mem_req(r_mem_req), .mem_wstrb(r_mem_wstrb), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_addr_ok(r_addr_ok), .mem_data_ok(r_data_ok), .mem_rdata(r_rdata),
    .proto_err(r_proto_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h3C01_0001;
      32'h8000_1000: return 32'h1111_2222;
      32'h8000_2000: return 32'h1234_5678;
      default:       return ~a;
    endcase
  endfunction

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t inst_q[$];
  exp_t data_q[$];
  int   rv_count = 0;

  // mem_req activity log for dut0
  logic        prev_req = 1'b0;
  int          last_rise = -1, run_len = 0, last_len = 0;
  logic [3:0]  rise_wstrb = '0;
  logic [31:0] rise_addr = '0, rise_wdata = '0;

  initial begin : monitor0
    exp_t e;
    forever begin
      @(negedge clk);
      if (inst_rvalid === 1'b1) begin
        rv_count++;
        if (inst_q.size() == 0) check("inst_rvalid_unexpected", 32'(inst_rvalid), 32'd0);
        else begin
          e = inst_q.pop_front();
          check("inst_rdata", inst_rdata, e.rdata);
          check("inst_rvalid_cycle", cyc, e.cyc);
        end
      end
      if (data_rvalid === 1'b1) begin
        rv_count++;
        if (data_q.size() == 0) check("data_rvalid_unexpected", 32'(data_rvalid), 32'd0);
        else begin
          e = data_q.pop_front();
          check("data_rdata", data_rdata, e.rdata);
          check("data_rvalid_cycle", cyc, e.cyc);
        end
      end
      if (inst_rvalid === 1'b1 && data_rvalid === 1'b1) check("rvalid_overlap", 32'd1, 32'd0);
      if (mem_req && !prev_req) begin
        last_rise  = cyc;
        rise_wstrb = mem_wstrb;
        rise_addr  = mem_addr;
        rise_wdata = mem_wdata;
      end
      if (mem_req) run_len++;
      else if (prev_req) begin
        last_len = run_len;
        run_len  = 0;
      end
      prev_req = mem_req;
    end
  end

  // Downstream memory model for dut0 with programmable handshake delays
  int addr_dly = 0, data_dly = 0, a_cnt = 0, d_cnt = 0;
  bit resp_en = 1'b1, in_data = 1'b0;

  initial begin : responder0
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        if (mem_req) begin
          if (a_cnt >= addr_dly) begin
            mem_addr_ok = 1'b1;
            a_cnt = 0;
            in_data = 1'b1;
            d_cnt = 0;
          end else a_cnt++;
        end else if (in_data) begin
          if (d_cnt >= data_dly) begin
            mem_data_ok = 1'b1;
            mem_rdata   = mem_word(mem_addr);
            in_data     = 1'b0;
          end else d_cnt++;
        end
      end
    end
  end

  // dut1 memory: immediate addr_ok, data_ok one cycle later
  logic r_pend = 1'b0;
  assign r_addr_ok = r_mem_req;
  assign r_rdata   = r_mem_addr ^ 32'hFFFF_0000;
  initial begin : responder1
    r_data_ok = 1'b0;
    forever begin
      @(negedge clk);
      r_data_ok = r_pend;
      r_pend    = r_mem_req;
    end
  end

  logic [31:0] glog[$];
  logic        r_prev_req = 1'b0;
  int          r_rv = 0;
  initial begin : monitor1
    forever begin
      @(negedge clk);
      if (r_mem_req && !r_prev_req) glog.push_back(r_mem_addr);
      r_prev_req = r_mem_req;
      if (r_inst_rvalid === 1'b1) begin
        r_rv++;
        check("rr_inst_rdata", r_inst_rdata, 32'hEFFF_0000);
      end
      if (r_data_rvalid === 1'b1) begin
        r_rv++;
        check("rr_data_rdata", r_data_rdata, 32'hDFFF_0000);
      end
      if (r_inst_rvalid === 1'b1 && r_data_rvalid === 1'b1) check("rr_rvalid_overlap", 32'd1, 32'd0);
    end
  end

  task automatic issue_inst(input logic [31:0] a, input logic [31:0] rd, input int lat);
    exp_t e;
    inst_addr = a;
    inst_req  = 1'b1;
    e.rdata = rd;
    e.cyc   = cyc + lat;
    inst_q.push_back(e);
  endtask

  task automatic issue_data(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int lat);
    exp_t e;
    data_wen   = wen;
    data_addr  = a;
    data_wdata = wd;
    data_req   = 1'b1;
    e.rdata = rd;
    e.cyc   = cyc + lat;
    data_q.push_back(e);
  endtask

  task automatic wait_done(input bit is_data, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
      if (is_data ? data_rvalid : inst_rvalid) begin
        done = 1'b1;
        if (is_data) data_req = 1'b0;
        else         inst_req = 1'b0;
      end
    end
    if (!done) begin
      check(name, 32'd0, 32'd1);
      if (is_data) data_req = 1'b0;
      else         inst_req = 1'b0;
    end
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t0, rv0, n;
    logic [31:0] act;
    logic [31:0] order [4];
    rst = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    r_inst_req = 1'b0; r_inst_addr = '0;
    r_data_req = 1'b0; r_data_wen = '0; r_data_addr = '0; r_data_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_inst_rdata", inst_rdata, 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // single fetch, immediate handshake
    t0 = cyc;
    issue_inst(32'hBFC0_0000, 32'h3C01_0001, 3);
    wait_done(1'b0, "t1_timeout");
    check("t1_mem_req_cycle", 32'(last_rise - t0), 32'd1);
    repeat (2) @(negedge clk);
    check("t1_inst_rdata_held", inst_rdata, 32'h3C01_0001);

    // simultaneous requests, data priority
    t0 = cyc;
    issue_data(4'b0000, 32'h8000_1000, 32'h0, 32'h1111_2222, 3);
    issue_inst(32'hBFC0_0004, 32'h403F_FFFB, 7);
    fork
      wait_done(1'b1, "t2_data_timeout");
      wait_done(1'b0, "t2_inst_timeout");
      begin
        for (int k = 0; k < 8; k++) begin
          #1;
          check($sformatf("t2_stall_if_c%0d", k), 32'(stall_if), (k <= 6) ? 32'd1 : 32'd0);
          @(negedge clk);
        end
      end
    join
    check("t2_inst_mem_req_cycle", 32'(last_rise - t0), 32'd5);
    @(negedge clk);

    // store with delayed handshakes
    addr_dly = 2;
    data_dly = 3;
    issue_data(4'b0011, 32'h8000_4000, 32'hAABB_CCDD, 32'h1111_2222, 8);
    wait_done(1'b1, "t4_timeout");
    check("t4_mem_req_len", 32'(last_len), 32'd3);
    check("t4_mem_wstrb", 32'(rise_wstrb), 32'h3);
    check("t4_mem_addr", rise_addr, 32'h8000_4000);
    check("t4_mem_wdata", rise_wdata, 32'hAABB_CCDD);
    addr_dly = 0;
    data_dly = 0;
    @(negedge clk);
    check("t4_data_rdata_kept", data_rdata, 32'h1111_2222);

    // load then store: load value survives the store ack
    issue_data(4'b0000, 32'h8000_2000, 32'h0, 32'h1234_5678, 3);
    wait_done(1'b1, "t6_load_timeout");
    @(negedge clk);
    issue_data(4'b1111, 32'h8000_2004, 32'hCAFE_BABE, 32'h1234_5678, 3);
    wait_done(1'b1, "t6_store_timeout");
    repeat (2) @(negedge clk);
    check("t6_data_rdata_kept", data_rdata, 32'h1234_5678);
    check("t6_proto_err_clean", 32'(proto_err), 32'd0);

    // reset while waiting for data_ok
    data_dly  = 10;
    data_wen  = 4'b0000;
    data_addr = 32'h8000_3000;
    data_req  = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_in_data_phase", {30'd0, mem_req, stall_mem}, 32'd1);
    #2;
    resp_en = 1'b0;
    in_data = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    rst = 1'b0;
    data_req = 1'b0;
    #1;
    check("t5_rst_mem_addr", mem_addr, 32'd0);
    check("t5_rst_mem_wdata", mem_wdata, 32'd0);
    check("t5_rst_data_rdata", data_rdata, 32'd0);
    check("t5_rst_inst_rdata", inst_rdata, 32'd0);
    check("t5_rst_ctl", {27'd0, mem_req, inst_rvalid, data_rvalid, stall_if, stall_mem}, 32'd0);
    rv0 = rv_count;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_no_rvalid_after_rst", 32'(rv_count - rv0), 32'd0);
    check("t5_proto_err_before", 32'(proto_err), 32'd0);
    mem_data_ok = 1'b1;
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    check("t5_proto_err_set", 32'(proto_err), 32'd1);
    repeat (3) @(negedge clk);
    check("t5_proto_err_sticky", 32'(proto_err), 32'd1);
    check("t5_idle_after_stray", 32'(mem_req), 32'd0);

    // round-robin on dut1: one fetch first so data wins the first contention
    r_inst_addr = 32'h1000_0000;
    r_inst_req  = 1'b1;
    n = 0;
    while (n < 50 && r_inst_rvalid !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("t3_warmup_done", 32'(r_inst_rvalid), 32'd1);
    r_inst_req = 1'b0;
    @(negedge clk);
    glog.delete();
    rv0 = r_rv;
    r_data_addr = 32'h2000_0000;
    r_data_req  = 1'b1;
    r_inst_req  = 1'b1;
    repeat (15) @(negedge clk);
    r_data_req = 1'b0;
    r_inst_req = 1'b0;
    repeat (4) @(negedge clk);
    order[0] = 32'h2000_0000;
    order[1] = 32'h1000_0000;
    order[2] = 32'h2000_0000;
    order[3] = 32'h1000_0000;
    check("t3_grant_count", glog.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      act = (i < glog.size()) ? glog[i] : 32'd0;
      check($sformatf("t3_grant%0d", i), act, order[i]);
    end
    check("t3_rvalid_count", 32'(r_rv - rv0), 32'd4);
    check("t3_proto_err", 32'(r_proto_err), 32'd0);

    check("inst_q_drained", inst_q.size(), 32'd0);
    check("data_q_drained", data_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
